// File: rtl/event_record_serializer_if.sv
// event_record_serializer_if: FIFO read side, byte stream and status of the record serializer
// master: serializer (drives fifo_rd, byte_data/byte_valid, busy, counters)
// slave: environment (drives enable, fifo_empty/fifo_data, byte_ready)
interface event_record_serializer_if #(
    parameter int REC_W = 47,
    parameter int CNT_W = 32
);
    logic             enable;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [REC_W-1:0] fifo_data;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             byte_ready;
    logic             busy;
    logic [CNT_W-1:0] records_sent;
    logic [15:0]      wraps_seen;

    modport master (
        input  enable, fifo_empty, fifo_data, byte_ready,
        output fifo_rd, byte_data, byte_valid, busy, records_sent, wraps_seen
    );

    modport slave (
        output enable, fifo_empty, fifo_data, byte_ready,
        input  fifo_rd, byte_data, byte_valid, busy, records_sent, wraps_seen
    );
endinterface

// File: rtl/event_record_serializer.sv
// event_record_serializer: pops REC_W-bit records from the capture FIFO and streams each MSB-first as NBYTES bytes
// Ports: clk; reset (async, active-high); bus (master) = enable, fifo_empty/fifo_rd/fifo_data,
// byte_data/byte_valid/byte_ready, busy, records_sent, wraps_seen
module event_record_serializer #(
    parameter int REC_W  = 47,
    parameter int NBYTES = 6,
    parameter int CNT_W  = 32
) (
    input logic                       clk,
    input logic                       reset,
    event_record_serializer_if.master bus
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, READ, LATCH, SEND} state_t;

    state_t        state, nxt;
    logic [W-1:0]  shift;
    logic [IW-1:0] idx;
    logic          wrap;
    logic          go, xfer, last;

    assign go            = bus.enable && !bus.fifo_empty;
    assign xfer          = bus.byte_valid && bus.byte_ready;
    assign last          = idx == IW'(NBYTES - 1);
    assign bus.byte_data = shift[W-1 -: 8];

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= nxt;

    always_comb begin
        nxt         = state;
        bus.fifo_rd = state == READ;
        bus.busy    = state != IDLE;
        case (state)
            IDLE:    nxt = go ? READ : IDLE;
            READ:    nxt = LATCH;
            LATCH:   nxt = SEND;
            SEND:    nxt = (xfer && last) ? (go ? READ : IDLE) : SEND;
            default: nxt = IDLE;
        endcase
    end

    // The top record bit is the tagger's wraparound flag; it is kept aside because the shift register loses it.
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            shift            <= '0;
            idx              <= '0;
            wrap             <= 1'b0;
            bus.byte_valid   <= 1'b0;
            bus.records_sent <= '0;
            bus.wraps_seen   <= '0;
        end else if (state == LATCH) begin
            shift          <= W'(bus.fifo_data);
            wrap           <= bus.fifo_data[REC_W-1];
            idx            <= '0;
            bus.byte_valid <= 1'b1;
        end else if (state == SEND && xfer) begin
            if (last) begin
                bus.byte_valid   <= 1'b0;
                bus.records_sent <= bus.records_sent + CNT_W'(1);
                bus.wraps_seen   <= bus.wraps_seen + {15'd0, wrap};
            end else begin
                shift <= shift << 8;
                idx   <= idx + IW'(1);
            end
        end
endmodule

// File: tb/tb_event_record_serializer.sv
// tb_event_record_serializer: vector table, corner sequences and random traffic against a byte-queue model
module tb_event_record_serializer;
    localparam int REC_W  = 47;
    localparam int NBYTES = 6;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    event_record_serializer_if #(.REC_W(REC_W), .CNT_W(CNT_W)) bus ();

    event_record_serializer #(.REC_W(REC_W), .NBYTES(NBYTES), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .reset(rst),
        .bus(bus)
    );

    typedef struct {
        logic [47:0]             rec;
        logic [NBYTES-1:0][7:0]  bytes;
        logic                    wrap;
    } vec_t;

    int n_chk, n_fail, cyc, lat_due, in_frame, exp_sent, exp_wraps;
    bit inflight, stall_prev;
    logic [7:0] prev_byte;
    logic [REC_W-1:0] fifo_q[$];
    logic [REC_W-1:0] rec_q[$];
    logic [7:0] exp_b[$];
    logic [7:0] rx_q[$];
    int rx_cyc[$];
    int rd_cyc[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] frame_byte(input logic [REC_W-1:0] r, input int k);
        return 8'((64'(r) >> (8 * (NBYTES - 1 - k))) & 64'hFF);
    endfunction

    task automatic push(input logic [REC_W-1:0] r);
        fifo_q.push_back(r);
        rec_q.push_back(r);
        for (int k = 0; k < NBYTES; k++) exp_b.push_back(frame_byte(r, k));
        bus.fifo_empty = 1'b0;
    endtask

    task automatic clear_obs();
        rx_q.delete();
        rx_cyc.delete();
        rd_cyc.delete();
    endtask

    // One clock: sample at the falling edge, play the FIFO, score transfers that the next rising edge commits.
    task automatic cycle(input logic rdy);
        logic [REC_W-1:0] r;
        @(negedge clk);
        bus.byte_ready = rdy;
        cyc++;
        if (lat_due == cyc) chk("latency_byte0_valid", bus.byte_valid, 1);
        if (stall_prev) begin
            chk("stall_valid_held", bus.byte_valid, 1);
            chk("stall_data_held", bus.byte_data, prev_byte);
        end
        if (bus.fifo_rd) begin
            chk("rd_while_nonempty", bus.fifo_empty, 0);
            rd_cyc.push_back(cyc);
            lat_due  = cyc + 2;
            inflight = 1'b1;
            if (fifo_q.size() > 0) bus.fifo_data = fifo_q.pop_front();
            bus.fifo_empty = fifo_q.size() == 0;
        end
        if (bus.byte_valid && rdy) begin
            rx_q.push_back(bus.byte_data);
            rx_cyc.push_back(cyc);
            if (exp_b.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL stream_byte: got %0h with no byte pending (cycle %0d)", bus.byte_data, cyc);
            end else chk("stream_byte", bus.byte_data, exp_b.pop_front());
            in_frame++;
            if (in_frame == NBYTES) begin
                in_frame = 0;
                inflight = 1'b0;
                if (rec_q.size() > 0) begin
                    r = rec_q.pop_front();
                    exp_sent++;
                    exp_wraps += int'(r[46]);
                end
            end
        end
        stall_prev = bus.byte_valid && !rdy;
        prev_byte  = bus.byte_data;
    endtask

    task automatic model_reset();
        if (inflight) begin
            for (int k = in_frame; k < NBYTES; k++) if (exp_b.size() > 0) exp_b.delete(0);
            if (rec_q.size() > 0) rec_q.delete(0);
        end
        inflight   = 1'b0;
        in_frame   = 0;
        exp_sent   = 0;
        exp_wraps  = 0;
        stall_prev = 1'b0;
        lat_due    = -1;
    endtask

    task automatic run_bytes(input string name, input int n, input int budget, input bit bp);
        for (int k = 0; k < budget && rx_q.size() < n; k++)
            cycle(bp ? logic'(k % 4 == 0 || k % 4 == 3) : 1'b1);
        chk({name, "_byte_count"}, rx_q.size(), n);
    endtask

    task automatic chk_counters(input string name);
        chk({name, "_records_sent"}, bus.records_sent, 64'(exp_sent));
        chk({name, "_wraps_seen"}, bus.wraps_seen, 64'(exp_wraps & 16'hFFFF));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[6];
        int wsum, acc;
        logic [7:0] one_frame[6];
        vt[0] = '{48'h7123_4567_89AB, {8'h71, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB}, 1'b1};
        vt[1] = '{48'h0000_0000_0001, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01}, 1'b0};
        vt[2] = '{48'h7FFF_FFFF_FFFF, {8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b1};
        vt[3] = '{48'h3FFF_FFFF_FFFF, {8'h3F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 1'b0};
        vt[4] = '{48'h4000_0000_0000, {8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 1'b1};
        vt[5] = '{48'h2A5A_C3E1_0F96, {8'h2A, 8'h5A, 8'hC3, 8'hE1, 8'h0F, 8'h96}, 1'b0};
        one_frame = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        n_chk = 0; n_fail = 0; cyc = 0; wsum = 0;
        model_reset();
        bus.enable = 1'b0; bus.fifo_empty = 1'b1; bus.byte_ready = 1'b0; bus.fifo_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_fifo_rd", bus.fifo_rd, 0);
        chk("reset_byte_valid", bus.byte_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_byte_data", bus.byte_data, 0);
        chk("reset_records_sent", bus.records_sent, 0);
        chk("reset_wraps_seen", bus.wraps_seen, 0);
        rst = 1'b0;
        bus.enable = 1'b1;

        for (int i = 0; i < 6; i++) begin
            clear_obs();
            push(vt[i].rec[REC_W-1:0]);
            run_bytes("vec", NBYTES, 20, 1'b0);
            cycle(1'b1);
            for (int k = 0; k < rx_q.size() && k < NBYTES; k++)
                chk("vec_byte", rx_q[k], vt[i].bytes[NBYTES-1-k]);
            chk("vec_rd_pulses", rd_cyc.size(), 1);
            if (rd_cyc.size() > 0 && rx_cyc.size() == NBYTES) begin
                chk("vec_rd_to_byte0", rx_cyc[0] - rd_cyc[0], 2);
                chk("vec_consecutive", rx_cyc[NBYTES-1] - rx_cyc[0], NBYTES - 1);
            end
            wsum += int'(vt[i].wrap);
            chk("vec_records_sent", bus.records_sent, i + 1);
            chk("vec_wraps_seen", bus.wraps_seen, wsum);
            chk("vec_busy_after", bus.busy, 0);
        end

        clear_obs();
        push(vt[0].rec[REC_W-1:0]);
        push(47'h1234_5678_9ABC);
        run_bytes("bp", 2 * NBYTES, 120, 1'b1);
        for (int k = 0; k < rx_q.size() && k < NBYTES; k++)
            chk("bp_byte", rx_q[k], vt[0].bytes[NBYTES-1-k]);
        chk("bp_rd_pulses", rd_cyc.size(), 2);
        if (rd_cyc.size() > 1 && rx_cyc.size() >= NBYTES)
            chk("bp_second_rd_after_last", rd_cyc[1], rx_cyc[NBYTES-1] + 1);
        cycle(1'b1);
        chk_counters("bp");

        clear_obs();
        push(47'h0123_4567_89AB);
        push(47'h3EDC_BA98_7654);
        push(47'h2000_0000_0000);
        run_bytes("b2b", 3 * NBYTES, 60, 1'b0);
        chk("b2b_rd_pulses", rd_cyc.size(), 3);
        if (rx_cyc.size() == 3 * NBYTES) begin
            chk("b2b_frame_gap1", rx_cyc[NBYTES] - rx_cyc[0], NBYTES + 2);
            chk("b2b_frame_gap2", rx_cyc[2 * NBYTES] - rx_cyc[NBYTES], NBYTES + 2);
        end
        cycle(1'b1);
        chk_counters("b2b");

        clear_obs();
        push(47'h5555_AAAA_5555);
        push(47'h0F0F_F0F0_0F0F);
        run_bytes("en_head", 2, 20, 1'b0);
        bus.enable = 1'b0;
        repeat (30) cycle(1'b1);
        chk("en_frame_done", rx_q.size(), NBYTES);
        chk("en_rd_gated", rd_cyc.size(), 1);
        chk("en_busy_low", bus.busy, 0);
        bus.enable = 1'b1;
        run_bytes("en_resume", 2 * NBYTES, 40, 1'b0);
        chk("en_rd_resumed", rd_cyc.size(), 2);
        cycle(1'b1);
        chk_counters("en");

        clear_obs();
        push(vt[0].rec[REC_W-1:0]);
        run_bytes("rst_head", 3, 20, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_byte_valid", bus.byte_valid, 0);
        chk("rst_records_sent", bus.records_sent, 0);
        chk("rst_wraps_seen", bus.wraps_seen, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_byte_data", bus.byte_data, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        push(47'h0000_0000_0001);
        run_bytes("rst_after", NBYTES, 20, 1'b0);
        for (int k = 0; k < rx_q.size() && k < NBYTES; k++)
            chk("rst_after_byte", rx_q[k], one_frame[k]);
        cycle(1'b1);
        chk("rst_after_records_sent", bus.records_sent, 1);
        chk("rst_after_wraps_seen", bus.wraps_seen, 0);

        acc = 0;
        for (int k = 0; k < 100; k++) begin
            cycle(1'b1);
            acc |= int'(bus.fifo_rd | bus.byte_valid | bus.busy);
        end
        chk("empty_fifo_quiet", acc, 0);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0 && fifo_q.size() < 4)
                push(REC_W'({$urandom, $urandom}));
            if ($urandom_range(0, 31) == 0) bus.enable = ~bus.enable;
            cycle(logic'($urandom_range(0, 3) != 0));
        end
        bus.enable = 1'b1;
        for (int k = 0; k < 400 && (exp_b.size() > 0 || fifo_q.size() > 0); k++) cycle(1'b1);
        chk("rand_drain_complete", exp_b.size(), 0);
        cycle(1'b1);
        chk_counters("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
